// File: rtl/alu_pkg.sv
// Shared definitions for the R-type issue stage: MIPS funct codes, ALU select
// codes, stage states and the funct-to-select decoder.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_AW     = 5;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] SEL_AND = 4'd0;
  localparam logic [3:0] SEL_OR  = 4'd1;
  localparam logic [3:0] SEL_ADD = 4'd2;
  localparam logic [3:0] SEL_SUB = 4'd6;
  localparam logic [3:0] SEL_SLT = 4'd7;
  localparam logic [3:0] SEL_NOR = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] sel;
  } dec_t;

  // Only op==0 R-type encodings with a supported funct are legal.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.legal = (op == 6'd0);
    d.sel   = SEL_AND;
    case (funct)
      FUNCT_AND: d.sel = SEL_AND;
      FUNCT_OR:  d.sel = SEL_OR;
      FUNCT_ADD: d.sel = SEL_ADD;
      FUNCT_SUB: d.sel = SEL_SUB;
      FUNCT_SLT: d.sel = SEL_SLT;
      FUNCT_NOR: d.sel = SEL_NOR;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 2^AW x DATA_W register file: two operand read ports, one debug read port,
// one synchronous write port. Register 0 always reads 0 and ignores writes.
module reg_file import alu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = DEF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 1 << AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    regs_d = regs_q;
    if (we && wa != '0) regs_d[wa] = wd;
  end

  // NOTE: this array is cleared on reset on purpose; the block must read all-zero registers after reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : regs_q[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : regs_q[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/rtype_issue.sv
// Operand fetch, decode and writeback around an external combinational ALU.
// One R-type instruction per three cycles; illegal encodings pulse err.
module rtype_issue import alu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = DEF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_z,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              err,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [AW-1:0]     rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d, wb_data_q, wb_data_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              wb_zero_q, wb_zero_d;

  logic [AW-1:0]     rs, rt, rd, rf_wa;
  logic [DATA_W-1:0] rs_data, rt_data, rf_wd;
  logic              rf_we;
  dec_t              dec;
  logic              unused_shamt;

  assign rs = in_instr[21 +: AW];
  assign rt = in_instr[16 +: AW];
  assign rd = in_instr[11 +: AW];
  assign dec = decode(in_instr[31:26], in_instr[5:0]);
  // shamt plays no part in R-type ALU decode.
  assign unused_shamt = ^in_instr[10:6];

  reg_file #(.DATA_W(DATA_W), .AW(AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (rs),
    .ra_data  (rs_data),
    .rb_addr  (rt),
    .rb_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (rf_wa),
    .wd       (rf_wd)
  );

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    alu_sel_d = alu_sel_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_zero_d = wb_zero_q;
    rf_we     = 1'b0;
    rf_wa     = ld_addr;
    rf_wd     = ld_data;
    case (state_q)
      IDLE: begin
        if (ld_en) begin
          rf_we = 1'b1;
        end else if (in_valid) begin
          rd_d    = rd;
          alu_x_d = rs_data;
          alu_y_d = rt_data;
          if (dec.legal) begin
            alu_sel_d = dec.sel;
            state_d   = EXEC;
          end else begin
            state_d = ERR;
          end
        end
      end
      EXEC: begin
        rf_we     = 1'b1;
        rf_wa     = rd_q;
        rf_wd     = alu_r;
        wb_rd_d   = rd_q;
        wb_data_d = alu_r;
        wb_zero_d = alu_z;
        state_d   = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      alu_sel_q <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      alu_sel_q <= alu_sel_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_zero_q <= wb_zero_d;
    end
  end

  // Ready is held low while reset is asserted, even though the state is already IDLE.
  assign in_ready = rst_n && (state_q == IDLE) && !ld_en;
  assign wb_valid = (state_q == WB);
  assign err      = (state_q == ERR);
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_sel  = alu_sel_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_zero  = wb_zero_q;

endmodule
